drlp_img_rd: RTL
================

Name: drlp_img_rd

Overview:
- Read-side controller for the DRLP image buffer.
- Takes a 2-D window descriptor (base, stride, rows, cols) and generates the buffer read address/enable sequence in raster order.
- Captures the buffer's combinational read data into an output register and streams the 48-bit words to the PE array over a valid/ready handshake, tagging the last word.

Parameters:
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 12, buffer address width (depth 4096).
- TOTAL_DATA_WIDTH, DATA_WIDTH*6, buffer word width (6 pixels).
- DIM_WIDTH, 8, width of the row/col count fields.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_base  in  ADDR_WIDTH  first word address.
- i_stride  in  ADDR_WIDTH  address increment between rows.
- i_rows  in  DIM_WIDTH  number of rows.
- i_cols  in  DIM_WIDTH  words per row.
- o_rd_en  out  1  buffer read enable.
- o_rd_addr  out  ADDR_WIDTH  buffer read address (registered).
- i_rd_data  in  TOTAL_DATA_WIDTH  buffer read data, combinational from o_rd_addr.
- o_valid  out  1  output word valid.
- i_ready  in  1  consumer ready.
- o_data  out  TOTAL_DATA_WIDTH  output word.
- o_last  out  1  qualifies the final word of the window.
- o_busy  out  1  high from the cycle after start until done.
- o_done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States:
  - IDLE: on i_start, latch base/stride/rows/cols, set o_rd_addr=i_base and row_base=i_base. If rows==0 or cols==0, go to FIN; else go to RUN.
  - RUN:
    - adv = !o_valid || i_ready; o_rd_en = RUN && adv.
    - On adv: o_data<=i_rd_data, o_valid<=1, o_last<=(row==rows-1 && col==cols-1).
    - Then advance: if col<cols-1, col+1 and addr+1; else col=0, row+1, row_base+=stride, addr=new row_base.
    - After issuing the last word, go to DRAIN.
    - If !adv, address and counters hold and o_rd_en=0.
  - DRAIN: wait until o_valid && i_ready with o_last, then clear o_valid/o_last and go to FIN.
  - FIN: o_done=1 for one cycle, go to IDLE.
- o_busy = state!=IDLE.
- Latency: start sampled at edge k → first o_valid after edge k+1. Full throughput of 1 word/cycle while i_ready=1.
- Output hold: o_data/o_last stable while o_valid && !i_ready.
- Address arithmetic: all address arithmetic is modulo 2^ADDR_WIDTH. Wrap past 4095 is legal and wraps to 0.
- Zero-size window: rows==0 or cols==0 → no reads, o_valid never set, o_done pulses 2 cycles after start.
- i_start outside IDLE is ignored; parameter inputs are don't-care outside IDLE.
- Reset mid-operation returns immediately to IDLE with all outputs 0; no partial done.
- Buffer writes may coincide with reads; read data is taken as presented (no hazard handling in this block).

Optional Feature:
- Macro DRLP_IMG_RD_PAD_EN.
- Defined:
  - Adds input i_pad (1 bit, latched at start).
  - When i_pad=1, the window is traversed as (rows+2)x(cols+2).
  - Border positions emit o_data=0 with o_rd_en=0 and the address not advanced.
  - Interior positions read normally.
  - o_last marks the final border word.
- Undefined: i_pad is absent and behaviour is exactly as above.

Test Plan:
- Basic window: base=0x010, stride=0x020, rows=2, cols=3, ready=1, buffer word[a]=a → o_data sequence 0x010, 0x011, 0x012, 0x030, 0x031, 0x032 on 6 consecutive cycles. o_last only on 0x032; o_done 1 cycle after.
- Backpressure: same window, i_ready toggling 1,0,0,1 repeating → no word lost or duplicated; o_data stable while stalled; o_rd_en=0 on stalled cycles.
- Wrap: base=0xFFE, stride=0x004, rows=2, cols=3 → addresses 0xFFE, 0xFFF, 0x000, 0x002, 0x003, 0x004.
- Zero size: rows=0, cols=5 → o_rd_en never high, o_valid never high, o_done pulses at start+2.
- Reset mid-run: assert i_rst_n=0 after the 2nd word of a rows=4, cols=4 window → all outputs 0 immediately. A new start afterwards runs the full 16-word sequence correctly.
- (PAD_EN) i_pad=1, rows=1, cols=1, base=0x005 → 9 words: zeros except the centre word = word[0x005]; exactly one read issued.

Source files
------------

// File: rtl/drlp_img_rd.sv
// drlp_img_rd: raster-order read controller for the DRLP image buffer, streaming words to the PE array.
// Optional zero-border padding of the window is compiled in when DRLP_IMG_RD_PAD_EN is defined.
module drlp_img_rd #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 12,
  parameter int TOTAL_DATA_WIDTH = DATA_WIDTH*6,
  parameter int DIM_WIDTH        = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base,
  input  logic [ADDR_WIDTH-1:0]       i_stride,
  input  logic [DIM_WIDTH-1:0]        i_rows,
  input  logic [DIM_WIDTH-1:0]        i_cols,
`ifdef DRLP_IMG_RD_PAD_EN
  input  logic                        i_pad,
`endif
  output logic                        o_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_rd_addr,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_rd_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [TOTAL_DATA_WIDTH-1:0] o_data,
  output logic                        o_last,
  output logic                        o_busy,
  output logic                        o_done
);

  // One extra bit so a padded window (dims + 2) still fits in the counters.
  localparam int CW = DIM_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]       row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0]       stride_q, stride_d;
  logic [CW-1:0]               rows_q, rows_d;
  logic [CW-1:0]               cols_q, cols_d;
  logic [CW-1:0]               row_q, row_d;
  logic [CW-1:0]               col_q, col_d;
  logic [TOTAL_DATA_WIDTH-1:0] data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        pad_q, pad_d;

  logic                        pad_in;
  logic                        adv;
  logic                        row_end;
  logic                        last_pos;
  logic                        border;
  logic                        data_row_end;
  logic                        rd_en;
  logic [CW-1:0]               pad_ext;
  logic [ADDR_WIDTH-1:0]       next_row_base;

`ifdef DRLP_IMG_RD_PAD_EN
  assign pad_in = i_pad;
`else
  assign pad_in = 1'b0;
`endif

  // rows_q/cols_q hold the traversed dimensions, already widened by the border when padding.
  assign pad_ext       = {{(CW-1){1'b0}}, pad_q};
  assign adv           = !valid_q || i_ready;
  assign row_end       = (col_q == cols_q - CW'(1));
  assign last_pos      = row_end && (row_q == rows_q - CW'(1));
  assign border        = pad_q && ((row_q == '0) || (row_q == rows_q - CW'(1)) ||
                                   (col_q == '0) || row_end);
  assign data_row_end  = (col_q == cols_q - CW'(1) - pad_ext);
  assign next_row_base = row_base_q + stride_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_d      = row_q;
    col_d      = col_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    pad_d      = pad_q;
    rd_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d     = i_base;
          row_base_d = i_base;
          stride_d   = i_stride;
          rows_d     = CW'(i_rows) + (pad_in ? CW'(2) : CW'(0));
          cols_d     = CW'(i_cols) + (pad_in ? CW'(2) : CW'(0));
          row_d      = '0;
          col_d      = '0;
          pad_d      = pad_in;
          if ((i_rows == '0) || (i_cols == '0)) state_d = ST_FIN;
          else                                  state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (adv) begin
          rd_en   = !border;
          data_d  = border ? '0 : i_rd_data;
          valid_d = 1'b1;
          last_d  = last_pos;
          // Border positions consume no buffer word, so the address only moves on reads.
          if (!border) begin
            if (data_row_end) begin
              row_base_d = next_row_base;
              addr_d     = next_row_base;
            end else begin
              addr_d = addr_q + ADDR_WIDTH'(1);
            end
          end
          if (row_end) begin
            col_d = '0;
            row_d = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (last_pos) state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (valid_q && i_ready && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_FIN;
        end
      end

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      pad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_q      <= row_d;
      col_q      <= col_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      pad_q      <= pad_d;
    end
  end

  assign o_rd_en   = rd_en;
  assign o_rd_addr = addr_q;
  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_last    = last_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = (state_q == ST_FIN);

endmodule
